ex_div: RTL and testbench

//  Multi-cycle 32/32 radix-2 restoring divider for the EX stage. Consumes the operands that the ID/EX

---
 rtl/ex_div_if.sv | 12 +
 rtl/ex_div.sv | 85 ++++++++
 tb/tb_ex_div.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// ex_div_if: operand/result bundle between the EX stage (master) and the divider (slave)
interface ex_div_if #(parameter int DATA_W = 32);
  logic              signed_div;
  logic [DATA_W-1:0] opdata1;
  logic [DATA_W-1:0] opdata2;
  logic              start;
  logic              annul;
  logic [2*DATA_W-1:0] result;
  logic              ready;
  modport master (output signed_div, opdata1, opdata2, start, annul, input result, ready);
  modport slave  (input signed_div, opdata1, opdata2, start, annul, output result, ready);
endinterface

// File: rtl/ex_div.sv
// ex_div: multi-cycle radix-2 restoring divider returning {remainder, quotient}
// Optional DIV_BYZERO_FAST_EN: divisor==0 short-circuits to a zero result in two cycles.
module ex_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic     clk,
  input logic     rst,
  ex_div_if.slave div
);
  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W:0]   r_work;
  logic [DATA_W-1:0]   r_dvs;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;
  logic [DATA_W-1:0]   w_a_abs;
  logic [DATA_W-1:0]   w_b_abs;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  assign w_a_abs = (div.signed_div && div.opdata1[DATA_W-1]) ? -div.opdata1 : div.opdata1;
  assign w_b_abs = (div.signed_div && div.opdata2[DATA_W-1]) ? -div.opdata2 : div.opdata2;
  // Partial remainder with the next dividend bit already shifted in sits in work[2W-1:W].
  assign w_diff  = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_dvs};
  assign w_quot  = r_work[DATA_W-1:0];
  assign w_rem   = r_work[2*DATA_W:DATA_W+1];
  assign div.result = r_result;
  assign div.ready  = r_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_ready  <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_FREE: begin
          r_ready  <= 1'b0;
          r_result <= '0;
          if (div.start && !div.annul) begin
            r_neg_q <= div.signed_div && (div.opdata1[DATA_W-1] ^ div.opdata2[DATA_W-1]);
            r_neg_r <= div.signed_div && div.opdata1[DATA_W-1];
            r_dvs   <= w_b_abs;
            r_work  <= {{DATA_W{1'b0}}, w_a_abs, 1'b0};
            r_cnt   <= '0;
`ifdef DIV_BYZERO_FAST_EN
            r_state <= (div.opdata2 == '0) ? S_BYZERO : S_ON;
`else
            r_state <= S_ON;
`endif
          end
        end
        S_ON: begin
          if (div.annul) begin
            r_state <= S_FREE;
          end else if (r_cnt == CNT_W'(DATA_W)) begin
            r_result <= {r_neg_r ? -w_rem : w_rem, r_neg_q ? -w_quot : w_quot};
            r_ready  <= 1'b1;
            r_state  <= S_END;
          end else begin
            r_work <= w_diff[DATA_W] ? {r_work[2*DATA_W-1:0], 1'b0}
                                     : {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        S_END: begin
          if (div.annul || !div.start) begin
            r_state  <= S_FREE;
            r_ready  <= 1'b0;
            r_result <= '0;
          end
        end
        S_BYZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= S_END;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed vectors for ex_div with hand-computed {remainder, quotient}
module tb_ex_div;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  ex_div_if div ();
  ex_div dut (.clk(clk), .rst(rst), .div(div));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input int lat);
    int n;
    div.signed_div = sd;
    div.opdata1    = a;
    div.opdata2    = b;
    div.annul      = 1'b0;
    div.start      = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) begin
        div.opdata1 = ~a;
        div.opdata2 = ~b;
      end
      if (div.ready) break;
    end
    check({tag, " lat"}, 64'(n), 64'(lat));
    check({tag, " res"}, div.result, {r, q});
    @(posedge clk);
    #1;
    check({tag, " hold"}, {63'b0, div.ready}, 64'd1);
    div.start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " drop"}, {div.result[62:0], div.ready}, 64'd0);
  endtask
  task automatic quiet(input string tag, input int cycles);
    int hits = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (div.ready) hits++;
    end
    check(tag, 64'(hits), 64'd0);
  endtask
  initial begin
    rst = 1'b1;
    div.signed_div = 1'b0;
    div.opdata1 = '0;
    div.opdata2 = '0;
    div.start = 1'b0;
    div.annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {div.result[62:0], div.ready}, 64'd0);
    rst = 1'b0;
    run_op("divu100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_op("div-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run_op("div7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33);
    run_op("div_min_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
    run_op("div-100_-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 33);
    run_op("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33);
    run_op("divu7_100", 1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 33);
`ifdef DIV_BYZERO_FAST_EN
    run_op("divu5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1);
`else
    run_op("divu5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 33);
`endif
    // annul mid-operation, then reissue
    div.signed_div = 1'b0;
    div.opdata1 = 32'd1000;
    div.opdata2 = 32'd3;
    div.start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    div.annul = 1'b1;
    div.start = 1'b0;
    @(posedge clk);
    #1;
    div.annul = 1'b0;
    check("annul rdy", {63'b0, div.ready}, 64'd0);
    quiet("annul quiet", 40);
    run_op("divu1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);
    // reset mid-operation
    div.opdata1 = 32'd1000;
    div.opdata2 = 32'd3;
    div.start = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    div.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst mid", {div.result[62:0], div.ready}, 64'd0);
    quiet("rst quiet", 40);
    // reset while a result is being held
    div.opdata1 = 32'd100;
    div.opdata2 = 32'd7;
    div.start = 1'b1;
    repeat (36) @(posedge clk);
    #1;
    check("end held", div.result, {32'd2, 32'd14});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    div.start = 1'b0;
    check("rst end", {div.result[62:0], div.ready}, 64'd0);
    // start with annul held must not launch
    div.opdata1 = 32'd9;
    div.opdata2 = 32'd3;
    div.start = 1'b1;
    div.annul = 1'b1;
    quiet("start+annul", 40);
    run_op("divu9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
